uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with oversampled mid-bit sampling, a one-byte
// holding register and sticky frame-error / overrun flags.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       rxclk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       rx_in,
  input  logic       uld_rx_data,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);

  // The E0 edge itself is sample 0 of the start bit, so the start-bit
  // middle is reached when the counter shows OVERSAMPLE/2-2 (E0 + OVERSAMPLE/2-1).
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(OVERSAMPLE / 2 - 2);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e              state_q,     state_d;
  logic [1:0]          sync_q,      sync_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [IDX_W-1:0]    bit_idx_q,   bit_idx_d;
  logic [DATA_W-1:0]   shift_q,     shift_d;
  logic [DATA_W-1:0]   rx_data_q,   rx_data_d;
  logic                rx_empty_q,  rx_empty_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q,   overrun_d;
  logic                rxs;
  logic                load_c;

  // Synchronized serial line; every line decision uses this.
  assign rxs = sync_q[1];

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx_in};
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_empty_d  = rx_empty_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    load_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (rx_enable && !rxs) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (!rx_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == START_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (!rx_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BIT_LAST) begin
          shift_d   = {rxs, shift_q[DATA_W-1:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (!rx_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BIT_LAST) begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Unload acknowledges the held byte; a coincident load overrides it below.
    if (uld_rx_data) begin
      rx_empty_d  = 1'b1;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (load_c) begin
      rx_data_d  = shift_q;
      rx_empty_d = 1'b0;
      if (uld_rx_data) begin
        frame_err_d = !rxs;
        overrun_d   = 1'b0;
      end else begin
        frame_err_d = frame_err_q | !rxs;
        overrun_d   = overrun_q | !rx_empty_q;
      end
    end
  end

  // All state, including the synchronizer and output registers.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_empty_q  <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_empty_q  <= rx_empty_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_empty     = rx_empty_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;

endmodule
